// File: rtl/vending_fsm_multi.sv
// Vending controller with a multi-line cart, overflow-checked totals and greedy coin-by-coin change.
// Latency: every output is registered and reflects an input pulse one sys_clk edge later.
// Backpressure: none; overflowing coins are rejected back out and full-cart adds pulse sel_err. Optional macro PAY_TIMEOUT_EN.
module vending_fsm_multi #(
  parameter int          MAX_ITEMS   = 4,
  parameter int          QTY_W       = 2,
  parameter int          TOTAL_W     = 7,
  parameter int          MONEY_W     = 8,
  parameter logic [31:0] PAY_TIMEOUT = 32'd500_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               sys_Goods,
  input  logic               sys_Confirm,
  input  logic               sys_Change,
  input  logic               sys_Cancel,
  input  logic [4:0]         coin_in,
  input  logic [2:0]         type_SW_high,
  input  logic [2:0]         type_SW_low,
  input  logic [QTY_W-1:0]   num_SW,
  output logic [TOTAL_W-1:0] total_money,
  output logic [MONEY_W-1:0] input_money,
  output logic [MONEY_W-1:0] change_money,
  output logic [3:0]         item_count,
  output logic [4:0]         coin_out,
  output logic               coin_out_vld,
  output logic               sel_err,
  output logic               done,
  output logic [4:0]         state_out
);

  localparam logic [4:0] S_IDLE    = 5'h01;
  localparam logic [4:0] S_SELECT  = 5'h02;
  localparam logic [4:0] S_PAYMENT = 5'h04;
  localparam logic [4:0] S_CHANGE  = 5'h08;
  localparam logic [4:0] S_REFUND  = 5'h10;

  localparam int LINE_W = QTY_W + 4;
  localparam int SUM_W  = ((TOTAL_W > LINE_W) ? TOTAL_W : LINE_W) + 1;
  localparam int PAY_W  = (TOTAL_W > MONEY_W) ? TOTAL_W : MONEY_W;

  logic [4:0]         state;
  logic [TOTAL_W-1:0] cart [8];
  logic [2:0]         last_idx;
  logic [3:0]         unit_price;
  logic               code_ok;
  logic [LINE_W-1:0]  line_price;
  logic [SUM_W-1:0]   new_total;
  logic               add_ok;
  logic [4:0]         coin_sel;
  logic [MONEY_W-1:0] coin_val;
  logic [MONEY_W:0]   money_sum;
  logic               pay_ok;
  logic [4:0]         pick_coin;
  logic [MONEY_W-1:0] pick_val;
  logic               pay_expired;
  logic               to_idle;

  assign state_out = state;
  assign last_idx  = 3'(item_count - 4'd1);

  // Price lookup, line cost, coin decode and greedy change pick.
  always_comb begin
    unit_price = 4'd0;
    code_ok    = 1'b1;
    case ({type_SW_high, type_SW_low})
      6'o11: unit_price = 4'd3;   6'o12: unit_price = 4'd4;
      6'o13: unit_price = 4'd6;   6'o14: unit_price = 4'd3;
      6'o21: unit_price = 4'd10;  6'o22: unit_price = 4'd8;
      6'o23: unit_price = 4'd9;   6'o24: unit_price = 4'd7;
      6'o31: unit_price = 4'd4;   6'o32: unit_price = 4'd6;
      6'o33: unit_price = 4'd15;  6'o34: unit_price = 4'd8;
      6'o41: unit_price = 4'd9;   6'o42: unit_price = 4'd4;
      6'o43: unit_price = 4'd5;   6'o44: unit_price = 4'd5;
      default: code_ok = 1'b0;
    endcase
    line_price = {4'b0, num_SW} * {{QTY_W{1'b0}}, unit_price};
    new_total  = SUM_W'(total_money) + SUM_W'(line_price);
    // Anything spilling above bit TOTAL_W-1 means the cart total would not fit.
    add_ok     = code_ok && (num_SW != '0) && (item_count != 4'(MAX_ITEMS))
                 && (new_total[SUM_W-1:TOTAL_W] == '0);

    // Several coin bits at once: keep only the lowest one.
    coin_sel = coin_in & (~coin_in + 5'd1);
    case (coin_sel)
      5'b00001: coin_val = MONEY_W'(1);
      5'b00010: coin_val = MONEY_W'(5);
      5'b00100: coin_val = MONEY_W'(10);
      5'b01000: coin_val = MONEY_W'(20);
      5'b10000: coin_val = MONEY_W'(50);
      default:  coin_val = '0;
    endcase
    money_sum = {1'b0, input_money} + {1'b0, coin_val};
    pay_ok    = PAY_W'(input_money) >= PAY_W'(total_money);

    if (change_money >= MONEY_W'(50)) begin
      pick_coin = 5'b10000; pick_val = MONEY_W'(50);
    end else if (change_money >= MONEY_W'(20)) begin
      pick_coin = 5'b01000; pick_val = MONEY_W'(20);
    end else if (change_money >= MONEY_W'(10)) begin
      pick_coin = 5'b00100; pick_val = MONEY_W'(10);
    end else if (change_money >= MONEY_W'(5)) begin
      pick_coin = 5'b00010; pick_val = MONEY_W'(5);
    end else begin
      pick_coin = 5'b00001; pick_val = MONEY_W'(1);
    end
  end

`ifdef PAY_TIMEOUT_EN
  logic [31:0] pay_cnt;
  logic        coin_taken;

  assign coin_taken  = (state == S_PAYMENT) && !sys_Cancel && !sys_Confirm
                       && (coin_in != 5'b0) && !money_sum[MONEY_W];
  assign pay_expired = (state == S_PAYMENT) && (pay_cnt == PAY_TIMEOUT - 32'd1);

  // Inactivity counter: held at zero outside PAYMENT so it restarts on entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                             pay_cnt <= '0;
    else if (state != S_PAYMENT || coin_taken)  pay_cnt <= '0;
    else                                        pay_cnt <= pay_cnt + 32'd1;
  end
`else
  assign pay_expired = 1'b0;
`endif

  // Every path that lands back in IDLE, including recovery from a corrupt state.
  always_comb begin
    to_idle = 1'b0;
    case (state)
      S_IDLE:    to_idle = 1'b0;
      S_SELECT:  to_idle = sys_Cancel && (item_count == 4'd0);
      S_PAYMENT: to_idle = !sys_Cancel && pay_expired && (input_money == '0);
      S_CHANGE,
      S_REFUND:  to_idle = sys_Change && (change_money == '0);
      default:   to_idle = 1'b1;
    endcase
  end

  // Main FSM and datapath; pulse outputs default low every cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      total_money  <= '0;
      input_money  <= '0;
      change_money <= '0;
      item_count   <= '0;
      coin_out     <= '0;
      coin_out_vld <= 1'b0;
      sel_err      <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < 8; i++) cart[i] <= '0;
    end else begin
      coin_out     <= '0;
      coin_out_vld <= 1'b0;
      sel_err      <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: if (sys_Confirm && !sys_Cancel) state <= S_SELECT;
        S_SELECT: begin
          if (sys_Cancel) begin
            if (item_count != 4'd0) begin
              item_count  <= item_count - 4'd1;
              total_money <= total_money - cart[last_idx];
            end
          end else if (sys_Confirm) begin
            if (item_count != 4'd0) state <= S_PAYMENT;
          end else if (sys_Goods) begin
            if (add_ok) begin
              cart[item_count[2:0]] <= TOTAL_W'(line_price);
              item_count            <= item_count + 4'd1;
              total_money           <= TOTAL_W'(new_total);
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        S_PAYMENT: begin
          if (sys_Cancel || pay_expired) begin
            if (sys_Cancel || input_money != '0) begin
              state        <= S_REFUND;
              change_money <= input_money;
            end
          end else if (sys_Confirm) begin
            if (pay_ok) begin
              state        <= S_CHANGE;
              change_money <= MONEY_W'(PAY_W'(input_money) - PAY_W'(total_money));
            end
          end else if (coin_in != 5'b0) begin
            if (money_sum[MONEY_W]) begin
              coin_out     <= coin_sel;
              coin_out_vld <= 1'b1;
            end else begin
              input_money <= money_sum[MONEY_W-1:0];
            end
          end
        end
        S_CHANGE, S_REFUND: begin
          if (sys_Change) begin
            if (change_money != '0) begin
              change_money <= change_money - pick_val;
              coin_out     <= pick_coin;
              coin_out_vld <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (to_idle) begin
        state        <= S_IDLE;
        total_money  <= '0;
        input_money  <= '0;
        change_money <= '0;
        item_count   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Directed bench for vending_fsm_multi: cart, payment, change, refund, overflow, reset, optional timeout.
// Dispensed coins are predicted into a queue when stimulus is driven and matched as coin_out_vld fires.
// Checks sample on the falling edge; stimulus is driven on the falling edge and held one cycle.
module tb_vending_fsm_multi;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       sys_Goods, sys_Confirm, sys_Change, sys_Cancel;
  logic [4:0] coin_in;
  logic [2:0] type_SW_high, type_SW_low;
  logic [1:0] num_SW;
  logic [6:0] total_money;
  logic [7:0] input_money, change_money;
  logic [3:0] item_count;
  logic [4:0] coin_out, state_out;
  logic       coin_out_vld, sel_err, done;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_coin_q [$];

  localparam logic [4:0] C1 = 5'b00001, C5 = 5'b00010, C10 = 5'b00100,
                         C20 = 5'b01000, C50 = 5'b10000;

  vending_fsm_multi #(.PAY_TIMEOUT(32'd16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm),
    .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
    .coin_in(coin_in), .type_SW_high(type_SW_high), .type_SW_low(type_SW_low),
    .num_SW(num_SW), .total_money(total_money), .input_money(input_money),
    .change_money(change_money), .item_count(item_count), .coin_out(coin_out),
    .coin_out_vld(coin_out_vld), .sel_err(sel_err), .done(done), .state_out(state_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each dispensed coin is matched against the oldest prediction.
  always @(negedge sys_clk) begin
    if (coin_out_vld === 1'b1) begin
      logic [4:0] exp;
      exp = (exp_coin_q.size() > 0) ? exp_coin_q.pop_front() : 5'b00000;
      checks++;
      assert (coin_out === exp) else begin
        errors++;
        $error("FAIL coin_out: observed %b expected %b", coin_out, exp);
      end
    end
  end

  task automatic drive(input logic g, input logic cf, input logic cn, input logic ch,
                       input logic [4:0] coin, input logic [2:0] hi, input logic [2:0] lo,
                       input logic [1:0] q);
    sys_Goods = g; sys_Confirm = cf; sys_Cancel = cn; sys_Change = ch;
    coin_in = coin; type_SW_high = hi; type_SW_low = lo; num_SW = q;
    @(negedge sys_clk);
    sys_Goods = 1'b0; sys_Confirm = 1'b0; sys_Cancel = 1'b0; sys_Change = 1'b0;
    coin_in = 5'b0;
  endtask

  task automatic goods(input logic [2:0] hi, input logic [2:0] lo, input logic [1:0] q);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'b0, hi, lo, q);
  endtask
  task automatic confirm(); drive(1'b0, 1'b1, 1'b0, 1'b0, 5'b0, 3'd0, 3'd0, 2'd0); endtask
  task automatic cancel();  drive(1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 3'd0, 3'd0, 2'd0); endtask
  task automatic change();  drive(1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 3'd0, 3'd0, 2'd0); endtask
  task automatic coin(input logic [4:0] c); drive(1'b0, 1'b0, 1'b0, 1'b0, c, 3'd0, 3'd0, 2'd0); endtask

  // IDLE -> SELECT, cart of 0x21 x2 (20) + 0x33 x1 (15) = 35, -> PAYMENT.
  task automatic order35();
    confirm();
    goods(3'd2, 3'd1, 2'd2);
    goods(3'd3, 3'd3, 2'd1);
    check("cart35_total", total_money, 35);
    confirm();
    check("cart35_state", state_out, 5'h04);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    sys_Goods = 1'b0; sys_Confirm = 1'b0; sys_Change = 1'b0; sys_Cancel = 1'b0;
    coin_in = 5'b0; type_SW_high = 3'd0; type_SW_low = 3'd0; num_SW = 2'd0;
    repeat (3) @(negedge sys_clk);
    check("rst_state", state_out, 5'h01);
    check("rst_outputs", {total_money, input_money, change_money, item_count, coin_out,
                          coin_out_vld, sel_err, done}, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 1: order and greedy change
    confirm();
    check("t1_select", state_out, 5'h02);
    goods(3'd2, 3'd1, 2'd2);
    goods(3'd3, 3'd3, 2'd1);
    check("t1_total", total_money, 35);
    check("t1_count", item_count, 2);
    confirm();
    coin(C50);
    check("t1_input", input_money, 50);
    confirm();
    check("t1_change_state", state_out, 5'h08);
    check("t1_change_amt", change_money, 15);
    exp_coin_q.push_back(C10); change();
    check("t1_after10", change_money, 5);
    exp_coin_q.push_back(C5);  change();
    check("t1_after5", change_money, 0);
    change();
    check("t1_done", done, 1);
    check("t1_idle", state_out, 5'h01);
    check("t1_cleared", total_money, 0);

    // 2: cart full, invalid code, zero qty, total overflow, empty confirm
    confirm();
    goods(3'd1, 3'd1, 2'd1); goods(3'd1, 3'd2, 2'd1);
    goods(3'd1, 3'd3, 2'd1); goods(3'd1, 3'd4, 2'd1);
    check("t2_full_total", total_money, 16);
    goods(3'd2, 3'd1, 2'd1);
    check("t2_full_err", sel_err, 1);
    check("t2_full_count", item_count, 4);
    cancel(); cancel(); cancel();
    check("t2_cancel_count", item_count, 1);
    check("t2_cancel_total", total_money, 3);
    goods(3'd1, 3'd5, 2'd1);
    check("t2_badcode_err", sel_err, 1);
    goods(3'd2, 3'd2, 2'd0);
    check("t2_qty0_err", sel_err, 1);
    goods(3'd3, 3'd3, 2'd3);
    check("t2_ok_noerr", sel_err, 0);
    goods(3'd3, 3'd3, 2'd3);
    check("t2_total93", total_money, 93);
    goods(3'd3, 3'd3, 2'd3);
    check("t2_ovf_err", sel_err, 1);
    check("t2_ovf_total", total_money, 93);
    cancel(); cancel(); cancel();
    check("t2_empty", item_count, 0);
    confirm();
    check("t2_empty_confirm", state_out, 5'h02);
    cancel();
    check("t2_back_idle", state_out, 5'h01);

    // 3: refund, multi-bit coin takes lowest bit
    order35();
    coin(C20);
    coin(C20 | C1);
    check("t3_input", input_money, 21);
    cancel();
    check("t3_refund_state", state_out, 5'h10);
    check("t3_refund_amt", change_money, 21);
    exp_coin_q.push_back(C20); change();
    exp_coin_q.push_back(C1);  change();
    change();
    check("t3_done", done, 1);
    check("t3_idle", state_out, 5'h01);

    // 4: insufficient funds then exact payment
    order35();
    coin(C20); coin(C10);
    confirm();
    check("t4_short_stays", state_out, 5'h04);
    coin(C5);
    confirm();
    check("t4_change_state", state_out, 5'h08);
    check("t4_change_zero", change_money, 0);
    change();
    check("t4_done", done, 1);
    check("t4_idle", state_out, 5'h01);

    // 5: coin overflow rejection
    order35();
    repeat (5) coin(C50);
    check("t5_input250", input_money, 250);
    exp_coin_q.push_back(C10);
    coin(C10);
    check("t5_reject_vld", coin_out_vld, 1);
    check("t5_input_held", input_money, 250);

    // 6: async reset mid-CHANGE
    confirm();
    check("t6_change_amt", change_money, 215);
    exp_coin_q.push_back(C50); change();
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_rst_state", state_out, 5'h01);
    check("t6_rst_outputs", {total_money, input_money, change_money, item_count, coin_out,
                             coin_out_vld, sel_err, done}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

`ifdef PAY_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      confirm();
      goods(3'd1, 3'd1, 2'd1);
      confirm();
      coin(C5);
      for (int c = 1; c <= 40; c++) begin
        @(negedge sys_clk);
        if (state_out === 5'h10) begin
          waited = c;
          break;
        end
      end
      check("t6_timeout_cycles", waited, 16);
      check("t6_timeout_state", state_out, 5'h10);
      check("t6_timeout_amt", change_money, 5);
      exp_coin_q.push_back(C5); change();
      change();
      check("t6_timeout_done", done, 1);
    end
`endif

    repeat (2) @(negedge sys_clk);
    check("coins_all_seen", exp_coin_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
